alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 33 +++
 rtl/rr_arbiter2.sv | 18 +
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, flag bit positions and FSM states shared by alu_arbiter
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_NOR = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
  localparam logic [3:0] OP_SRL = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // alu_flags = {equal, lessthan, carry, overflow, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_LT    = 3;
  localparam int FLAG_EQ    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_MUL;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; on a tie the requester not granted last wins
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters with settle-then-capture timing
// ALU_ARB_OPCHECK_EN: ops 1011..1111 are answered at once with rsp_err instead of being dispatched
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_s,
  input  logic [4:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic [4:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        last_q;
  logic        id_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [3:0]  alu_ctrl_q;
  logic [31:0] rsp_s_q;
  logic [4:0]  rsp_flags_q;

  logic [1:0]  gnt;
  logic        accept;
  logic        grant_id;
  logic [3:0]  sel_op;
  logic [31:0] sel_a, sel_b;
  logic        bad_op;
  logic        capture;

  rr_arbiter2 u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  assign grant_id = gnt[1];
  assign sel_op   = grant_id ? req_op[7:4]  : req_op[3:0];
  assign sel_a    = grant_id ? req_a[63:32] : req_a[31:0];
  assign sel_b    = grant_id ? req_b[63:32] : req_b[31:0];
  assign accept   = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign capture  = (state_q == ST_SETTLE) && (cnt_q == 4'd0);

`ifdef ALU_ARB_OPCHECK_EN
  assign bad_op = op_is_illegal(sel_op);
`else
  assign bad_op = 1'b0;
`endif

  // ready is gated by rst_n so no grant leaks out while reset is held
  assign req_ready = ((state_q == ST_IDLE) && rst_n) ? gnt : 2'b00;
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_id    = id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_flags = rsp_flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = bad_op ? ST_RESP : ST_SETTLE;
      ST_SETTLE: if (capture) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= 4'd0;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      alu_ctrl_q  <= 4'b0000;
      rsp_s_q     <= 32'd0;
      rsp_flags_q <= 5'd0;
    end else begin
      if (accept) begin
        last_q  <= grant_id;
        id_q    <= grant_id;
        alu_a_q <= sel_a;
        alu_b_q <= sel_b;
        cnt_q   <= SETTLE_LD;
        if (bad_op) begin
          rsp_s_q     <= 32'd0;
          rsp_flags_q <= 5'd0;
        end else begin
          alu_ctrl_q <= sel_op;
        end
      end else if ((state_q == ST_SETTLE) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        rsp_s_q     <= alu_s;
        rsp_flags_q <= alu_flags;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= bad_op;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU attached
module tb_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_ctrl;
  logic [4:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [31:0] rsp_s;
  logic [4:0]  rsp_flags;

  typedef struct packed {
    logic        id;
    logic [31:0] s;
    logic [4:0]  flags;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;

`ifdef ALU_ARB_OPCHECK_EN
  localparam int         BAD_LAT  = 0;
  localparam logic [3:0] BAD_CTRL = 4'b0101;
  localparam exp_t       BAD_EXP  = '{id: 1'b0, s: 32'd0, flags: 5'b00000, err: 1'b1};
`else
  localparam int         BAD_LAT  = 3;
  localparam logic [3:0] BAD_CTRL = 4'b1100;
  localparam exp_t       BAD_EXP  = '{id: 1'b0, s: 32'd0, flags: 5'b00001, err: 1'b0};
`endif

  alu_arbiter #(.SETTLE_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctrl  (alu_ctrl),
    .alu_s     (alu_s),
    .alu_flags (alu_flags),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_flags (rsp_flags),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU; carry on SUB means borrow
  logic [32:0] add_w, sub_w;
  logic        carry, ovf;
  assign add_w = {1'b0, alu_a} + {1'b0, alu_b};
  assign sub_w = {1'b0, alu_a} - {1'b0, alu_b};

  always_comb begin
    alu_s = 32'd0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_s = alu_a & alu_b;
      4'b0001: alu_s = alu_a | alu_b;
      4'b0101: begin
        alu_s = add_w[31:0];
        carry = add_w[32];
        ovf   = (alu_a[31] == alu_b[31]) && (add_w[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_s = sub_w[31:0];
        carry = sub_w[32];
        ovf   = (alu_a[31] != alu_b[31]) && (sub_w[31] != alu_a[31]);
      end
      default: alu_s = 32'd0;
    endcase
  end

  assign alu_flags = {alu_a == alu_b, $signed(alu_a) < $signed(alu_b), carry, ovf, alu_s == 32'd0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input exp_t e);
    sb.push_back(e);
    pushed++;
  endtask

  task automatic measure_latency(output int lat);
    lat = -1;
    if (rsp_valid) lat = 0;
    for (int i = 1; i <= 30 && lat < 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) lat = i;
    end
  endtask

  task automatic wait_ready(output logic [1:0] rr, output logic found);
    found = 1'b0;
    rr    = 2'b00;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        found = 1'b1;
        rr    = req_ready;
      end
    end
  endtask

  task automatic wait_rsp(output logic found);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid) found = 1'b1;
    end
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk(name, idle, 1'b1);
  endtask

  // monitor: every response handshake is matched against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d s %0h, expected no response", rsp_id, rsp_s);
        end else begin
          mon_e = sb.pop_front();
          popped++;
          chk("rsp_id", rsp_id, mon_e.id);
          chk("rsp_s", rsp_s, mon_e.s);
          chk("rsp_flags", rsp_flags, mon_e.flags);
          chk("rsp_err", rsp_err, mon_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic [1:0] rr;
    logic       found;

    rst_n = 1'b1; req_valid = 2'b11; req_op = 8'h00; req_a = 64'd0; req_b = 64'd0; rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_s", rsp_s, 32'd0);
    chk("rst_rsp_flags", rsp_flags, 5'd0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", alu_ctrl, 4'd0);
    chk("rst_busy", busy, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1; req_valid = 2'b00;

    // single request: 5 + 7
    @(posedge clk); #1;
    req_op = 8'h05; req_a = {32'd0, 32'd5}; req_b = {32'd0, 32'd7}; req_valid = 2'b01;
    push('{id: 1'b0, s: 32'd12, flags: 5'b01000, err: 1'b0});
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    chk("t1_alu_ctrl", alu_ctrl, 4'b0101);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd7);
    chk("t1_busy", busy, 1'b1);
    measure_latency(lat);
    chk("t1_latency", lat, 32'd3);
    wait_idle("t1_idle");

    // back-pressure: requester 1, 100 + 23, held for 10 cycles
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_op = 8'h50; req_a = {32'd100, 32'd0}; req_b = {32'd23, 32'd0}; req_valid = 2'b10;
    push('{id: 1'b1, s: 32'd123, flags: 5'b00000, err: 1'b0});
    @(negedge clk);
    chk("t3_ready", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b11;
    wait_rsp(found);
    chk("t3_rsp_seen", found, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1'b1);
      chk("t3_hold_s", rsp_s, 32'd123);
      chk("t3_hold_id", rsp_id, 1'b1);
      chk("t3_hold_ready", req_ready, 2'b00);
      chk("t3_hold_busy", busy, 1'b1);
    end
    @(posedge clk); #1 req_valid = 2'b00; rsp_ready = 1'b1;
    wait_idle("t3_idle");

    // both valid: 9 - 9, grants must alternate starting at 0
    @(posedge clk); #1;
    req_op = 8'h66; req_a = {32'd9, 32'd9}; req_b = {32'd9, 32'd9}; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) push('{id: k[0], s: 32'd0, flags: 5'b10001, err: 1'b0});
    for (int k = 0; k < 4; k++) begin
      wait_ready(rr, found);
      chk("t4_grant_seen", found, 1'b1);
      chk("t4_grant", rr, k[0] ? 2'b10 : 2'b01);
      @(posedge clk);
    end
    #1 req_valid = 2'b00;
    wait_idle("t4_idle");

    // reset during SETTLE abandons the operation and restores the tie pointer
    @(posedge clk); #1;
    req_op = 8'h05; req_a = {32'd0, 32'd1}; req_b = {32'd0, 32'd2}; req_valid = 2'b01;
    @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t5_req_ready", req_ready, 2'b00);
    chk("t5_rsp_valid", rsp_valid, 1'b0);
    chk("t5_rsp_s", rsp_s, 32'd0);
    chk("t5_rsp_flags", rsp_flags, 5'd0);
    chk("t5_rsp_id", rsp_id, 1'b0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_alu_b", alu_b, 32'd0);
    chk("t5_alu_ctrl", alu_ctrl, 4'd0);
    chk("t5_busy", busy, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 1'b0);
      chk("t5_no_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    req_op = 8'h55; req_a = {32'd10, 32'd3}; req_b = {32'd20, 32'd4}; req_valid = 2'b11;
    push('{id: 1'b0, s: 32'd7, flags: 5'b01000, err: 1'b0});
    wait_ready(rr, found);
    chk("t5_grant_seen", found, 1'b1);
    chk("t5_tie_grant", rr, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_idle("t5_idle");

    // op 1100: error response or normal dispatch depending on build
    @(posedge clk); #1;
    req_op = 8'h0c; req_a = {32'd0, 32'd8}; req_b = {32'd0, 32'd3}; req_valid = 2'b01;
    push(BAD_EXP);
    @(negedge clk);
    chk("t6_ready", req_ready, 2'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    chk("t6_alu_ctrl", alu_ctrl, BAD_CTRL);
    measure_latency(lat);
    chk("t6_latency", lat, BAD_LAT);
    wait_idle("t6_idle");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    chk("rsp_count", popped, pushed);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
